// File: rtl/pipelined_cla_adder.sv
// Two-level carry-lookahead adder (GROUP-bit groups, lookahead across groups) in a 2-stage valid/ready pipeline.
// Optional CLA_SUB_EN macro adds a 'sub' input selecting A + ~B + 1.
module pipelined_cla_adder #(
  parameter int WIDTH = 16,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
`ifdef CLA_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Ovf
);

  localparam int NGRP = (GROUP >= 1) ? (WIDTH / GROUP) : 1;

  generate
    if (GROUP < 1) begin : g_bad_group
      $error("pipelined_cla_adder: GROUP must be at least 1");
    end else if ((WIDTH % GROUP) != 0) begin : g_bad_width
      $error("pipelined_cla_adder: WIDTH must be a multiple of GROUP");
    end
  endgenerate

  // Stage-1 input conditioning: subtraction folds into the adder as A + ~B + 1.
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;
`ifdef CLA_SUB_EN
  assign b_eff   = sub ? ~B : B;
  assign cin_eff = sub ? 1'b1 : Cin;
`else
  assign b_eff   = B;
  assign cin_eff = Cin;
`endif

  logic [WIDTH-1:0] bit_g, bit_p;
  logic [NGRP-1:0]  grp_g, grp_p;

  assign bit_g = A & b_eff;
  assign bit_p = A ^ b_eff;

  always_comb begin
    logic gg, pg;
    // NOTE: every comb output gets a default first so no path can infer a latch.
    grp_g = '0;
    grp_p = '0;
    for (int k = 0; k < NGRP; k++) begin
      gg = 1'b0;
      pg = 1'b1;
      for (int i = 0; i < GROUP; i++) begin
        gg = bit_g[k*GROUP+i] | (bit_p[k*GROUP+i] & gg);
        pg = pg & bit_p[k*GROUP+i];
      end
      grp_g[k] = gg;
      grp_p[k] = pg;
    end
  end

  // Pipeline registers between the two stages.
  logic             s1_valid;
  logic [WIDTH-1:0] s1_g, s1_p;
  logic [NGRP-1:0]  s1_gg, s1_pg;
  logic             s1_cin, s1_a_msb, s1_b_msb;

  logic s2_adv, s1_accept;

  assign s2_adv    = !out_valid || out_ready;
  assign in_ready  = !s1_valid || s2_adv;
  assign s1_accept = in_valid && in_ready;

  // Stage 2: lookahead across groups, then ripple inside each group from its group carry.
  logic [NGRP:0]    grp_c;
  logic [WIDTH-1:0] carry;
  logic [WIDTH-1:0] s2_sum;
  logic             s2_cout, s2_ovf;

  always_comb begin
    logic c;
    grp_c    = '0;
    carry    = '0;
    grp_c[0] = s1_cin;
    for (int k = 0; k < NGRP; k++) begin
      grp_c[k+1] = s1_gg[k] | (s1_pg[k] & grp_c[k]);
    end
    for (int k = 0; k < NGRP; k++) begin
      c = grp_c[k];
      for (int i = 0; i < GROUP; i++) begin
        carry[k*GROUP+i] = c;
        c = s1_g[k*GROUP+i] | (s1_p[k*GROUP+i] & c);
      end
    end
  end

  assign s2_sum  = s1_p ^ carry;
  assign s2_cout = grp_c[NGRP];
  assign s2_ovf  = (s1_a_msb == s1_b_msb) && (s2_sum[WIDTH-1] != s1_a_msb);

  // NOTE: only the valid flag is reset in stage 1; its datapath is qualified by s1_valid
  // and so carries no reset, keeping the wide registers off the reset net.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
    end else if (s1_accept) begin
      s1_valid <= 1'b1;
    end else if (s2_adv) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (s1_accept) begin
      s1_g     <= bit_g;
      s1_p     <= bit_p;
      s1_gg    <= grp_g;
      s1_pg    <= grp_p;
      s1_cin   <= cin_eff;
      s1_a_msb <= A[WIDTH-1];
      s1_b_msb <= b_eff[WIDTH-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      Sum       <= '0;
      Cout      <= 1'b0;
      Ovf       <= 1'b0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        Sum  <= s2_sum;
        Cout <= s2_cout;
        Ovf  <= s2_ovf;
      end
    end
  end

endmodule
